// File: rtl/div_pkg.sv
// Shared types and sizing for the sequential restoring divider.
package div_pkg;
    localparam int DIV_N     = 4;
    localparam int DIV_CNT_W = $clog2(DIV_N);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } div_state_e;

    // Keeps the counter at least one bit wide when N is 1.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/seq_divider_if.sv
// Operand/result bus of the divider; same start/ready handshake as the multiplier.
interface seq_divider_if import div_pkg::*; #(
    parameter int N = DIV_N
);
    logic           start;
    logic [2*N-1:0] dividendBus;
    logic [N-1:0]   divisorBus;
    logic           ready;
    logic           done;
    logic [N-1:0]   quotBus;
    logic [N-1:0]   remBus;
    logic           ovf;

    modport master (
        output start, dividendBus, divisorBus,
        input  ready, done, quotBus, remBus, ovf
    );
    modport slave (
        input  start, dividendBus, divisorBus,
        output ready, done, quotBus, remBus, ovf
    );
endinterface

// File: rtl/div_step.sv
// One restoring shift-subtract step: shift {R,Q} left, trial-subtract D, keep or restore.
module div_step import div_pkg::*; #(
    parameter int N = DIV_N
) (
    input  logic [N:0]   r,
    input  logic [N-1:0] q,
    input  logic [N-1:0] d,
    output logic [N:0]   r_next,
    output logic [N-1:0] q_next,
    output logic         ge
);
    logic [N+1:0] r_sh;
    logic [N:0]   t;

    // Full-width compare so an out-of-range remainder still gives a deterministic result.
    assign r_sh   = {r, q[N-1]};
    assign t      = r_sh[N:0] - {1'b0, d};
    assign ge     = (r_sh >= {2'b00, d});
    assign r_next = ge ? t : r_sh[N:0];

    always_comb begin
        q_next    = q << 1;
        q_next[0] = ge;
    end
endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider: 2N/N -> N-bit quotient and remainder, one quotient bit per clock.
// Optional DIV_OVF_CHECK_EN: flag quotient overflow / divide-by-zero at accept and skip iteration.
module seq_divider import div_pkg::*; #(
    parameter int N = DIV_N
) (
    input  logic          clk,
    input  logic          rst_n,
    seq_divider_if.slave  bus
);
    localparam int CW = cnt_width(N);

    div_state_e    state_q, state_d;
    logic [N:0]    racc_q, racc_d;
    logic [N-1:0]  qacc_q, qacc_d;
    logic [N-1:0]  dvs_q, dvs_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  quot_q, quot_d;
    logic [N-1:0]  rem_q, rem_d;
    logic          ovf_q, ovf_d;

    logic          accept;
    logic          ovf_hit;
    logic [N:0]    step_r;
    logic [N-1:0]  step_q;
    logic          step_ge_unused;

    assign accept = (state_q == IDLE) && bus.start;

`ifdef DIV_OVF_CHECK_EN
    assign ovf_hit = (bus.dividendBus[2*N-1:N] >= bus.divisorBus);
`else
    assign ovf_hit = 1'b0;
`endif

    div_step #(.N(N)) u_step (
        .r      (racc_q),
        .q      (qacc_q),
        .d      (dvs_q),
        .r_next (step_r),
        .q_next (step_q),
        .ge     (step_ge_unused)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            racc_q  <= '0;
            qacc_q  <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            racc_q  <= racc_d;
            qacc_q  <= qacc_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.start) state_d = ovf_hit ? DONE : ITER;
            ITER:    if (cnt_q == '0) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Results are loaded on the edge entering DONE so they are valid alongside done.
    always_comb begin
        racc_d = racc_q;
        qacc_d = qacc_q;
        dvs_d  = dvs_q;
        cnt_d  = cnt_q;
        quot_d = quot_q;
        rem_d  = rem_q;
        ovf_d  = ovf_q;
        if (accept) begin
            racc_d = {1'b0, bus.dividendBus[2*N-1:N]};
            qacc_d = bus.dividendBus[N-1:0];
            dvs_d  = bus.divisorBus;
            cnt_d  = CW'(N-1);
            ovf_d  = ovf_hit;
            if (ovf_hit) begin
                quot_d = '1;
                rem_d  = '0;
            end
        end else if (state_q == ITER) begin
            racc_d = step_r;
            qacc_d = step_q;
            cnt_d  = cnt_q - CW'(1);
            if (cnt_q == '0) begin
                quot_d = step_q;
                rem_d  = step_r[N-1:0];
            end
        end
    end

    always_comb begin
        bus.ready = (state_q == IDLE);
        bus.done  = (state_q == DONE);
    end

    assign bus.quotBus = quot_q;
    assign bus.remBus  = rem_q;
    assign bus.ovf     = ovf_q;
endmodule

// File: tb/tb_seq_divider.sv
// Randomised self-checking bench for seq_divider against a plain-arithmetic divide model.
module tb_seq_divider;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    seq_divider_if #(.N(N)) bus ();

    seq_divider #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Issues one request from IDLE and waits (bounded) for done; lat=-1 on timeout.
    task automatic run_op(input logic [2*N-1:0] dvd, input logic [N-1:0] dvs,
                          output int lat, output logic [N-1:0] q,
                          output logic [N-1:0] r, output logic o);
        lat = -1; q = 'x; r = 'x; o = 1'bx;
        @(negedge clk);
        bus.start = 1'b1; bus.dividendBus = dvd; bus.divisorBus = dvs;
        @(negedge clk);
        bus.start = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            if (bus.done) begin
                lat = k; q = bus.quotBus; r = bus.remBus; o = bus.ovf;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        bus.start = 1'b0; bus.dividendBus = '0; bus.divisorBus = '0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (bus.ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%0b exp=1", bus.ready); end
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%0b exp=0", bus.done); end
        total++; if ({bus.quotBus, bus.remBus} !== 8'h00) begin bad++; $display("FAIL reset_results got=%0h exp=0", {bus.quotBus, bus.remBus}); end
        total++; if (bus.ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%0b exp=0", bus.ovf); end
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (bus.ready !== 1'b1) begin bad++; $display("FAIL post_reset_ready got=%0b exp=1", bus.ready); end
    endtask

    task automatic test_normal();
        int lat; logic [N-1:0] q, r; logic o;
        run_op(8'h64, 4'd7, lat, q, r, o);
        total++; if (lat !== N+1) begin bad++; $display("FAIL norm_latency got=%0d exp=%0d", lat, N+1); end
        total++; if (q !== 4'hE) begin bad++; $display("FAIL norm_quot got=%0h exp=e", q); end
        total++; if (r !== 4'h2) begin bad++; $display("FAIL norm_rem got=%0h exp=2", r); end
        total++; if (o !== 1'b0) begin bad++; $display("FAIL norm_ovf got=%0b exp=0", o); end
        total++; if (bus.ready !== 1'b0) begin bad++; $display("FAIL norm_ready_in_done got=%0b exp=0", bus.ready); end
        @(negedge clk);
        total++; if (bus.ready !== 1'b1) begin bad++; $display("FAIL norm_ready_back got=%0b exp=1", bus.ready); end
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL norm_done_width got=%0b exp=0", bus.done); end
        total++; if (bus.quotBus !== 4'hE) begin bad++; $display("FAIL norm_quot_held got=%0h exp=e", bus.quotBus); end
        run_op(8'h2D, 4'd3, lat, q, r, o);
        total++; if (q !== 4'hF) begin bad++; $display("FAIL exact_quot got=%0h exp=f", q); end
        total++; if (r !== 4'h0) begin bad++; $display("FAIL exact_rem got=%0h exp=0", r); end
        @(negedge clk);
    endtask

    task automatic test_random();
        int lat; logic [N-1:0] q, r; logic o;
        int dvs, hi, lo, dvd;
        for (int i = 0; i < 25; i++) begin
            dvs = $urandom_range(1, 15);
            hi  = $urandom_range(0, dvs - 1);
            lo  = $urandom_range(0, 15);
            dvd = hi * 16 + lo;
            run_op(8'(dvd), 4'(dvs), lat, q, r, o);
            total++;
            if (lat !== N+1 || q !== 4'(dvd / dvs) || r !== 4'(dvd % dvs) || o !== 1'b0) begin
                bad++;
                $display("FAIL rand_%0d %0d/%0d got lat=%0d q=%0d r=%0d ovf=%0b exp lat=%0d q=%0d r=%0d ovf=0",
                         i, dvd, dvs, lat, q, r, o, N+1, dvd / dvs, dvd % dvs);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_overflow();
        int lat; logic [N-1:0] q, r; logic o;
        logic [2*N-1:0] any_dvd;
        run_op(8'h50, 4'd5, lat, q, r, o);
`ifdef DIV_OVF_CHECK_EN
        total++; if (lat !== 1) begin bad++; $display("FAIL ovf_latency got=%0d exp=1", lat); end
        total++; if (o !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%0b exp=1", o); end
        total++; if ({q, r} !== 8'hF0) begin bad++; $display("FAIL ovf_results got=%0h exp=f0", {q, r}); end
        @(negedge clk);
        total++; if (bus.ready !== 1'b1) begin bad++; $display("FAIL ovf_ready_back got=%0b exp=1", bus.ready); end
        any_dvd = 8'($urandom_range(0, 255));
        run_op(any_dvd, 4'd0, lat, q, r, o);
        total++; if (lat !== 1 || o !== 1'b1 || {q, r} !== 8'hF0) begin bad++; $display("FAIL div0 got lat=%0d ovf=%0b qr=%0h exp lat=1 ovf=1 qr=f0", lat, o, {q, r}); end
        @(negedge clk);
        run_op(8'h64, 4'd7, lat, q, r, o);
        total++; if (o !== 1'b0 || {q, r} !== 8'hE2) begin bad++; $display("FAIL ovf_clear got ovf=%0b qr=%0h exp ovf=0 qr=e2", o, {q, r}); end
`else
        total++; if (lat !== N+1) begin bad++; $display("FAIL nochk_latency got=%0d exp=%0d", lat, N+1); end
        total++; if (o !== 1'b0) begin bad++; $display("FAIL nochk_ovf got=%0b exp=0", o); end
        any_dvd = 8'($urandom_range(0, 255));
        run_op(any_dvd, 4'd0, lat, q, r, o);
        total++; if (lat !== N+1 || o !== 1'b0) begin bad++; $display("FAIL nochk_div0 got lat=%0d ovf=%0b exp lat=%0d ovf=0", lat, o, N+1); end
`endif
        @(negedge clk);
    endtask

    task automatic test_busy_start();
        int ndone = 0; int k_done = -1;
        logic [N-1:0] q = 'x, r = 'x;
        @(negedge clk);
        bus.start = 1'b1; bus.dividendBus = 8'h64; bus.divisorBus = 4'd7;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            bus.start = (k == 2);
            if (k == 2) begin bus.dividendBus = 8'h2D; bus.divisorBus = 4'd3; end
            if (bus.done) begin ndone++; k_done = k; q = bus.quotBus; r = bus.remBus; end
        end
        bus.start = 1'b0;
        total++; if (ndone !== 1) begin bad++; $display("FAIL busy_done_count got=%0d exp=1", ndone); end
        total++; if (k_done !== N+1) begin bad++; $display("FAIL busy_latency got=%0d exp=%0d", k_done, N+1); end
        total++; if ({q, r} !== 8'hE2) begin bad++; $display("FAIL busy_results got=%0h exp=e2", {q, r}); end
    endtask

    task automatic test_reset_mid();
        int lat; int ndone = 0; logic [N-1:0] q, r; logic o;
        @(negedge clk);
        bus.start = 1'b1; bus.dividendBus = 8'h2D; bus.divisorBus = 4'd3;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.done) ndone++;
        end
        rst_n = 1'b0;
        #1;
        total++; if (bus.ready !== 1'b1) begin bad++; $display("FAIL rstmid_ready got=%0b exp=1", bus.ready); end
        total++; if ({bus.quotBus, bus.remBus, bus.ovf, bus.done} !== 10'h0) begin bad++; $display("FAIL rstmid_outputs got=%0h exp=0", {bus.quotBus, bus.remBus, bus.ovf, bus.done}); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (bus.done) ndone++;
        end
        total++; if (ndone !== 0) begin bad++; $display("FAIL rstmid_no_done got=%0d exp=0", ndone); end
        run_op(8'h64, 4'd7, lat, q, r, o);
        total++; if (lat !== N+1 || {q, r} !== 8'hE2) begin bad++; $display("FAIL rstmid_recover got lat=%0d qr=%0h exp lat=%0d qr=e2", lat, {q, r}, N+1); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int k1 = -1, k2 = -1;
        logic [7:0] qr1 = 'x, qr2 = 'x;
        @(negedge clk);
        bus.start = 1'b1; bus.dividendBus = 8'h64; bus.divisorBus = 4'd7;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (bus.done) begin
                if (k1 < 0) begin
                    k1 = k; qr1 = {bus.quotBus, bus.remBus};
                    bus.dividendBus = 8'h2D; bus.divisorBus = 4'd3;
                end else begin
                    k2 = k; qr2 = {bus.quotBus, bus.remBus};
                    bus.start = 1'b0;
                    break;
                end
            end
        end
        bus.start = 1'b0;
        total++; if (k1 !== N+1) begin bad++; $display("FAIL b2b_first_latency got=%0d exp=%0d", k1, N+1); end
        total++; if (k2 - k1 !== N+2) begin bad++; $display("FAIL b2b_spacing got=%0d exp=%0d", k2 - k1, N+2); end
        total++; if (qr1 !== 8'hE2) begin bad++; $display("FAIL b2b_first_results got=%0h exp=e2", qr1); end
        total++; if (qr2 !== 8'hF0) begin bad++; $display("FAIL b2b_second_results got=%0h exp=f0", qr2); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_normal();
        test_random();
        test_overflow();
        test_busy_start();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
